cirno9_sram_hs_ctrl: RTL and testbench

Handshake controller between the cirno9 core's load/store/fetch port and the `sram32` array. It accepts one core request at a time, adds a programmable number of wait states, drives the SRAM enable, write strobes, address and data for one cycle, and registers read data. It produces the `i_hs_ram4ls_rdy` completion strobe that the core otherwise sees tied high. Accesses outside the SRAM range are flagged and suppressed.

---
 rtl/cirno9_sram_hs_ctrl.sv | 136 +++++++++++++
 tb/tb_cirno9_sram_hs_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_sram_hs_ctrl.sv
// Handshake controller between the cirno9 load/store/fetch port and the sram32 array.
// One request at a time: latch, optional wait states, one-cycle SRAM access, registered completion.
module cirno9_sram_hs_ctrl #(
    parameter int AW       = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ren,
    input  logic [3:0]  i_wen,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic        o_rdy,
    output logic [31:0] o_rdat,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_mem_en,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_din,
    input  logic [31:0] i_mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CAPT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_wcnt;
    logic        r_is_wr;
    logic        r_oor;
    logic [3:0]  r_wen;
    logic [31:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        r_rdy;
    logic        r_err;
    logic        r_mem_en;
    logic [3:0]  r_mem_we;

    logic        w_req;
    logic        w_oor;

    assign w_req = i_ren | (|i_wen);
    assign w_oor = |i_adr[31:AW+2];

    // NOTE: every register is assigned with <= so all updates in this block see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wcnt   <= 4'd0;
            r_is_wr  <= 1'b0;
            r_oor    <= 1'b0;
            r_wen    <= 4'd0;
            r_adr    <= 32'd0;
            r_wdat   <= 32'd0;
            r_rdat   <= 32'd0;
            r_rdy    <= 1'b0;
            r_err    <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr   <= i_adr;
                        r_wdat  <= i_wdat;
                        r_wen   <= i_wen;
                        r_is_wr <= |i_wen;
                        r_oor   <= w_oor;
                        if (WAIT_CYC > 0) begin
                            r_state <= S_WAIT;
                            r_wcnt  <= WAIT_LOAD;
                        end else begin
                            // Strobes are registered on entry so they coincide with ACCESS.
                            r_state  <= S_ACCESS;
                            r_mem_en <= ~w_oor;
                            r_mem_we <= w_oor ? 4'd0 : i_wen;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state  <= S_ACCESS;
                        r_mem_en <= ~r_oor;
                        r_mem_we <= r_oor ? 4'd0 : r_wen;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 4'd0;
                    if (r_is_wr) begin
                        r_state <= S_DONE;
                        r_rdy   <= 1'b1;
                        r_err   <= r_oor;
                    end else begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_rdat  <= r_oor ? 32'd0 : i_mem_dout;
                    r_state <= S_DONE;
                    r_rdy   <= 1'b1;
                    r_err   <= r_oor;
                end
                S_DONE: begin
                    r_rdy   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset also masks the strobes at its own edge so an aborted ACCESS never commits to the array.
    assign o_mem_en  = r_mem_en & ~rst;
    assign o_mem_we  = r_mem_we & {4{~rst}};
    assign o_mem_adr = r_adr;
    assign o_mem_din = r_wdat;
    assign o_rdy     = r_rdy;
    assign o_rdat    = r_rdat;
    assign o_err     = r_err;
    assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_cirno9_sram_hs_ctrl.sv
// Self-checking bench for cirno9_sram_hs_ctrl: three instances (0, 2 and 15 wait states),
// each attached to its own behavioural sram32, checked against a spec-level transaction model.
module tb_cirno9_sram_hs_ctrl;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ren      [NI];
    logic [3:0]  wen      [NI];
    logic [31:0] adr      [NI];
    logic [31:0] wdat     [NI];
    logic        rdy      [NI];
    logic [31:0] rdat     [NI];
    logic        err      [NI];
    logic        busy     [NI];
    logic        mem_en   [NI];
    logic [3:0]  mem_we   [NI];
    logic [31:0] mem_adr  [NI];
    logic [31:0] mem_din  [NI];
    logic [31:0] mem_dout [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 2 : 15);
        cirno9_sram_hs_ctrl #(.AW(10), .WAIT_CYC(WC)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .i_ren      (ren[g]),
            .i_wen      (wen[g]),
            .i_adr      (adr[g]),
            .i_wdat     (wdat[g]),
            .o_rdy      (rdy[g]),
            .o_rdat     (rdat[g]),
            .o_err      (err[g]),
            .o_busy     (busy[g]),
            .o_mem_en   (mem_en[g]),
            .o_mem_we   (mem_we[g]),
            .o_mem_adr  (mem_adr[g]),
            .o_mem_din  (mem_din[g]),
            .i_mem_dout (mem_dout[g])
        );
    end

    function automatic int wc_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 2 : 15);
    endfunction

    // Behavioural sram32 arrays plus a backdoor port (op 1 = write word, op 2 = clear all).
    logic [31:0] sram [NI][DEPTH];
    logic [1:0]  bd_op;
    int          bd_g;
    int          bd_w;
    logic [31:0] bd_d;

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (mem_en[g]) begin
                if (mem_we[g] == 4'd0) begin
                    mem_dout[g] <= sram[g][mem_adr[g][11:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (mem_we[g][b]) sram[g][mem_adr[g][11:2]][8*b +: 8] <= mem_din[g][8*b +: 8];
                end
            end
        end
        if (bd_op == 2'd1) begin
            sram[bd_g][bd_w] <= bd_d;
        end else if (bd_op == 2'd2) begin
            for (int g = 0; g < NI; g++)
                for (int w = 0; w < DEPTH; w++) sram[g][w] <= 32'd0;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem  [NI][DEPTH];
    logic [31:0] ref_rdat [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          done;
        int          lat;
        int          en_cnt;
        int          we_cnt;
        int          we_cyc;
        logic [3:0]  we_val;
        logic [31:0] acc_adr;
        logic [31:0] acc_din;
        logic [31:0] rdat;
        logic        err;
        int          busy_low;
    } res_t;

    typedef struct {
        int          lat;
        logic        err;
        int          en_cnt;
        logic [31:0] rdat;
    } exp_t;

    typedef struct {
        logic        ren;
        logic [3:0]  wen;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          lat;
        logic        err;
        logic [31:0] rdat;
        int          en_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int g, input int w, input logic [31:0] d);
        bd_g = g; bd_w = w; bd_d = d; bd_op = 2'd1;
        @(negedge clk);
        bd_op = 2'd0;
        ref_mem[g][w] = d;
    endtask

    task automatic clear_mem();
        bd_op = 2'd2;
        @(negedge clk);
        bd_op = 2'd0;
        for (int g = 0; g < NI; g++) begin
            for (int w = 0; w < DEPTH; w++) ref_mem[g][w] = 32'd0;
            ref_rdat[g] = 32'd0;
        end
    endtask

    // Spec-level outcome of one transaction; updates the model's memory and read register.
    task automatic model_txn(input int g, input logic r, input logic [3:0] w,
                             input logic [31:0] a, input logic [31:0] d, output exp_t ex);
        logic oor;
        int   idx;
        oor = (a >= 32'h0000_1000);
        idx = int'(a[11:2]);
        if (w != 4'd0) begin
            ex.lat = wc_of(g) + 2;
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (w[b]) ref_mem[g][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            ex.lat = wc_of(g) + 3;
            if (r) ref_rdat[g] = oor ? 32'd0 : ref_mem[g][idx];
        end
        ex.err    = oor;
        ex.en_cnt = oor ? 0 : 1;
        ex.rdat   = ref_rdat[g];
    endtask

    // Called at a negedge with the DUT idle; returns at the IDLE negedge after completion.
    task automatic do_txn(input int g, input logic r, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input bit scr, output res_t res);
        int cyc;
        res.done = 0; res.lat = -1; res.en_cnt = 0; res.we_cnt = 0; res.we_cyc = 0;
        res.we_val = 4'd0; res.acc_adr = 32'd0; res.acc_din = 32'd0; res.rdat = 32'd0;
        res.err = 1'b0; res.busy_low = 0;
        ren[g] = r; wen[g] = w; adr[g] = a; wdat[g] = d;
        cyc = 0;
        while (!res.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!busy[g]) res.busy_low++;
            if (mem_en[g]) begin
                res.en_cnt++;
                res.acc_adr = mem_adr[g];
                res.acc_din = mem_din[g];
            end
            if (mem_we[g] != 4'd0) begin
                res.we_cnt++;
                res.we_cyc = cyc;
                res.we_val = mem_we[g];
            end
            if (rdy[g]) begin
                res.done = 1;
                res.lat  = cyc;
                res.rdat = rdat[g];
                res.err  = err[g];
            end else if (scr) begin
                ren[g]  = 1'($urandom_range(0, 1));
                wen[g]  = 4'($urandom);
                adr[g]  = $urandom;
                wdat[g] = $urandom;
            end
        end
        ren[g] = 1'b0;
        wen[g] = 4'd0;
        @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input int g, input logic r, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d, input bit scr,
                           output res_t res, output exp_t ex);
        model_txn(g, r, w, a, d, ex);
        do_txn(g, r, w, a, d, scr, res);
        check({tag, "_completed"}, 32'(res.done), 32'd1);
        check({tag, "_busy"}, 32'(res.busy_low), 32'd0);
    endtask

    task automatic check_zero(input string tag, input int g);
        check({tag, "_rdy"}, 32'(rdy[g]), 32'd0);
        check({tag, "_rdat"}, rdat[g], 32'd0);
        check({tag, "_err"}, 32'(err[g]), 32'd0);
        check({tag, "_busy"}, 32'(busy[g]), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en[g]), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we[g]), 32'd0);
        check({tag, "_mem_adr"}, mem_adr[g], 32'd0);
        check({tag, "_mem_din"}, mem_din[g], 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        res_t res;
        exp_t ex;
        int   idx, last, gap, nrdy;

        rst = 1'b1; bd_op = 2'd0; bd_g = 0; bd_w = 0; bd_d = 32'd0;
        for (int g = 0; g < NI; g++) begin
            ren[g] = 1'b0; wen[g] = 4'd0; adr[g] = 32'd0; wdat[g] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) check_zero($sformatf("reset%0d", g), g);

        clear_mem();
        preload(0, 5, 32'hDEAD_BEEF);
        preload(0, 8, 32'h1122_3344);
        preload(0, 1023, 32'h1357_9BDF);

        // Table: instance with no wait states.
        tbl[0] = '{1'b1, 4'h0, 32'h0000_0014, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 1};
        tbl[1] = '{1'b0, 4'h2, 32'h0000_0020, 32'h0000_AB00, 2, 1'b0, 32'hDEAD_BEEF, 1};
        tbl[2] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h1122_AB44, 1};
        tbl[3] = '{1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D, 2, 1'b0, 32'h1122_AB44, 1};
        tbl[4] = '{1'b1, 4'h0, 32'h0000_0030, 32'h0,         3, 1'b0, 32'hCAFE_F00D, 1};
        tbl[5] = '{1'b1, 4'h0, 32'h0000_1000, 32'h0,         3, 1'b1, 32'h0,         0};
        tbl[6] = '{1'b0, 4'hF, 32'h0000_1004, 32'hFFFF_FFFF, 2, 1'b1, 32'h0,         0};
        tbl[7] = '{1'b1, 4'h0, 32'h0000_0FFC, 32'h0,         3, 1'b0, 32'h1357_9BDF, 1};
        tbl[8] = '{1'b1, 4'h0, 32'h8000_0010, 32'h0,         3, 1'b1, 32'h0,         0};
        tbl[9] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         3, 1'b0, 32'h0,         1};
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("tbl%0d", i), 0, tbl[i].ren, tbl[i].wen, tbl[i].adr, tbl[i].wdat,
                    1'b0, res, ex);
            check($sformatf("tbl%0d_lat", i), 32'(res.lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_err", i), 32'(res.err), 32'(tbl[i].err));
            check($sformatf("tbl%0d_rdat", i), res.rdat, tbl[i].rdat);
            check($sformatf("tbl%0d_en_cnt", i), 32'(res.en_cnt), 32'(tbl[i].en_cnt));
        end

        // Byte write with two wait states, then readback.
        preload(1, 8, 32'h1122_3344);
        run_txn("bw", 1, 1'b0, 4'b0010, 32'h20, 32'h0000_AB00, 1'b0, res, ex);
        check("bw_lat", 32'(res.lat), 32'd4);
        check("bw_we_cyc", 32'(res.we_cyc), 32'd3);
        check("bw_we_cnt", 32'(res.we_cnt), 32'd1);
        check("bw_we_val", 32'(res.we_val), 32'b0010);
        check("bw_din", res.acc_din, 32'h0000_AB00);
        check("bw_adr", res.acc_adr, 32'h20);
        run_txn("bw_rb", 1, 1'b1, 4'd0, 32'h20, 32'h0, 1'b0, res, ex);
        check("bw_rb_lat", 32'(res.lat), 32'd5);
        check("bw_rb_rdat", res.rdat, 32'h1122_AB44);

        // Maximum wait count.
        preload(2, 7, 32'hA5A5_0001);
        run_txn("w15_rd", 2, 1'b1, 4'd0, 32'h1C, 32'h0, 1'b0, res, ex);
        check("w15_rd_lat", 32'(res.lat), 32'd18);
        check("w15_rd_rdat", res.rdat, 32'hA5A5_0001);
        run_txn("w15_wr", 2, 1'b0, 4'hF, 32'h1C, 32'h0000_0077, 1'b0, res, ex);
        check("w15_wr_lat", 32'(res.lat), 32'd17);
        run_txn("w15_rb", 2, 1'b1, 4'd0, 32'h1C, 32'h0, 1'b0, res, ex);
        check("w15_rb_rdat", res.rdat, 32'h0000_0077);

        // Back-to-back reads with the request held high.
        for (int i = 0; i < 4; i++) preload(0, 20 + i, 32'h1000_0000 + 32'(i));
        idx = 0; last = 0; gap = 0;
        ren[0] = 1'b1; wen[0] = 4'd0; adr[0] = 32'(20 * 4);
        model_txn(0, 1'b1, 4'd0, 32'(20 * 4), 32'h0, ex);
        for (int c = 1; c <= 40 && idx < 4; c++) begin
            @(negedge clk);
            if (!busy[0]) gap++;
            if (rdy[0]) begin
                check($sformatf("b2b%0d_rdat", idx), rdat[0], 32'h1000_0000 + 32'(idx));
                if (idx > 0) begin
                    check($sformatf("b2b%0d_period", idx), 32'(c - last), 32'd4);
                    check($sformatf("b2b%0d_idle_gap", idx), 32'(gap), 32'd1);
                end
                gap = 0; last = c; idx++;
                if (idx < 4) begin
                    adr[0] = 32'((20 + idx) * 4);
                    model_txn(0, 1'b1, 4'd0, 32'((20 + idx) * 4), 32'h0, ex);
                end
            end
        end
        ren[0] = 1'b0;
        check("b2b_count", 32'(idx), 32'd4);
        @(negedge clk);

        // Reset sampled during ACCESS aborts the write.
        preload(0, 40, 32'h0F0F_0F0F);
        ren[0] = 1'b0; wen[0] = 4'hF; adr[0] = 32'hA0; wdat[0] = 32'h55AA_55AA;
        @(negedge clk);
        check("rsta_in_access", 32'(mem_en[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wen[0] = 4'd0;
        check_zero("rsta_after", 0);
        for (int g = 0; g < NI; g++) ref_rdat[g] = 32'd0;
        nrdy = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[0]) nrdy++;
        end
        check("rsta_no_rdy", 32'(nrdy), 32'd0);
        run_txn("rsta_rb", 0, 1'b1, 4'd0, 32'hA0, 32'h0, 1'b0, res, ex);
        check("rsta_rb_rdat", res.rdat, 32'h0F0F_0F0F);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            int          g, kind;
            logic        r;
            logic [3:0]  w;
            logic [31:0] a, d;
            bit          scr;
            g    = $urandom_range(0, NI - 1);
            kind = $urandom_range(0, 2);
            r    = (kind != 1);
            w    = (kind == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom;
                if (a < 32'h1000) a = a | 32'h0001_0000;
            end else begin
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end
            d   = $urandom;
            scr = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", i), g, r, w, a, d, scr, res, ex);
            check($sformatf("rnd%0d_lat", i), 32'(res.lat), 32'(ex.lat));
            check($sformatf("rnd%0d_err", i), 32'(res.err), 32'(ex.err));
            check($sformatf("rnd%0d_en_cnt", i), 32'(res.en_cnt), 32'(ex.en_cnt));
            check($sformatf("rnd%0d_rdat", i), res.rdat, ex.rdat);
            if (ex.en_cnt == 1) check($sformatf("rnd%0d_adr", i), res.acc_adr, a);
            if (w != 4'd0) begin
                check($sformatf("rnd%0d_we_cnt", i), 32'(res.we_cnt), 32'(ex.en_cnt));
                if (ex.en_cnt == 1) begin
                    check($sformatf("rnd%0d_we_val", i), 32'(res.we_val), 32'(w));
                    check($sformatf("rnd%0d_din", i), res.acc_din, d);
                end
            end else begin
                check($sformatf("rnd%0d_no_we", i), 32'(res.we_cnt), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
